ibr128_avm_master: RTL and testbench
====================================

IBR128_AVM_MASTER -- requirements
Module: ibr128_avm_master

Interface
REQ-001 SHALL have parameter POLL_MAX, default 1024: maximum STA polls before timeout (used only with IBR128_AVM_TIMEOUT_EN).
REQ-002 SHALL have port Clk  in  1  clock; all logic on rising edge.
REQ-003 SHALL have port RstN  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port Start  in  1  single-cycle request to run one block operation.
REQ-005 SHALL have ports KeyIn  in  128, IvIn  in  128, PtIn  in  128: operation data; word 0 = bits [31:0].
REQ-006 SHALL have ports ModeEncrypt  in  1, ModeSA  in  1, ModeSOM  in  2, ModeFB  in  1: CTRL fields.
REQ-007 SHALL have ports Busy  out  1, Done  out  1 (one-cycle pulse), Err  out  1, CtOut  out  128 (ciphertext).
REQ-008 SHALL have Avalon-MM master ports CS  out  1, Write  out  1, Read  out  1, Addr  out  5, WData  out  32, RData  in  32.

Function
REQ-009 Start SHALL be accepted only in IDLE; Start while Busy SHALL be ignored.
REQ-010 On acceptance, Key/Iv/Pt/Mode inputs SHALL be latched internally; later input changes SHALL NOT affect the operation.
REQ-011 FSM states SHALL be IDLE, WR, POLL_REQ, POLL_CAP, CT_REQ, CT_CAP, DIS, DONE.
REQ-012 WR SHALL issue 13 back-to-back writes, one per cycle, CS=Write=1: Addr 0x00-0x03 IV words 0-3, 0x04-0x07 key words 0-3, 0x08-0x0B PT words 0-3, then 0x10 CTRL.
REQ-013 CTRL WData SHALL be {26'h0, FB, SOM[1:0], Encrypt, SA, 1'b1} (bit 0 = Enable).
REQ-014 POLL_REQ SHALL drive CS=Read=1, Addr=0x11 for one cycle; POLL_CAP (next cycle, CS=Read=0) SHALL sample RData.
REQ-015 POLL_CAP: RData[0]=1 -> CT_REQ with index 0; RData[0]=0 -> POLL_REQ.
REQ-016 CT_REQ SHALL read Addr 0x0C+i (CS=Read=1); CT_CAP SHALL store RData into CtOut[32i+31:32i]; i=0..3, then DIS.
REQ-017 DIS SHALL write CTRL with Enable=0, other fields unchanged, one cycle.
REQ-018 DONE SHALL assert Done for exactly one cycle, then return to IDLE.
REQ-019 Busy SHALL be 1 in every state except IDLE.
REQ-020 Read and Write SHALL never be 1 together; CS=0 whenever neither is 1; WData=0 when Write=0.
REQ-021 Minimum latency (ready on first poll): Start-accept cycle to Done = 24 cycles (13 WR + 2 poll + 8 CT + 1 DIS).
REQ-022 CtOut SHALL hold its value until the next operation's first CT_CAP; Err SHALL clear on next Start acceptance.

Reset
REQ-023 RstN low SHALL immediately force IDLE; CS, Write, Read, Addr, WData, Busy, Done, Err = 0; CtOut = 0; latched data and counters = 0.
REQ-024 Reset mid-operation SHALL abandon the transfer with no further bus cycles; the slave is not disabled (it resets with the same RstN).

Configuration
REQ-025 Macro IBR128_AVM_TIMEOUT_EN defined: poll counter (width clog2(POLL_MAX+1)) increments per POLL_CAP with RData[0]=0; reaching POLL_MAX SHALL set Err=1 and go to DIS, skipping CT reads (CtOut unchanged), then DONE.
REQ-026 Macro undefined: no counter, polling unbounded, Err tied to 0.

Structure
REQ-027 Shared package ibr128_pkg SHALL hold CSR address constants (IV0..CT3, CTRL=0x10, STA=0x11), CTRL bit positions, and the FSM state enum.
REQ-028 Single module; no sub-module; a 4-bit word index SHALL sequence WR and CT phases.

Verification
REQ-029 Slave model ready after 3 cycles, Key=0x0F..00, Iv=0x1F..10, Pt=0x2F..20 -> bus trace of 13 writes in order, CTRL WData=0x00000001 with modes 0, Done once, CtOut = model ciphertext.
REQ-030 Ready on first poll -> Done exactly 24 cycles after Start-accept cycle; exactly one STA read.
REQ-031 Start pulsed again at write 5 with different PtIn -> ignored; written PT = first latched value.
REQ-032 ModeEncrypt=1, SOM=2'b10, FB=1, SA=1 -> CTRL writes 0x00000037 then 0x00000036 in DIS.
REQ-033 RstN asserted during CT_REQ i=2 -> outputs zero same cycle, no bus activity after; fresh Start completes normally.
REQ-034 IBR128_AVM_TIMEOUT_EN, POLL_MAX=4, slave never ready -> 4 STA reads, DIS write, Done with Err=1, no CT reads.

Source files
------------

// File: rtl/ibr128_pkg.sv
// Shared definitions for the IBR128 Avalon-MM master: CSR map, CTRL fields
// and the sequencer state encoding.
package ibr128_pkg;

    localparam logic [4:0] ADDR_IV0  = 5'h00;
    localparam logic [4:0] ADDR_IV1  = 5'h01;
    localparam logic [4:0] ADDR_IV2  = 5'h02;
    localparam logic [4:0] ADDR_IV3  = 5'h03;
    localparam logic [4:0] ADDR_KEY0 = 5'h04;
    localparam logic [4:0] ADDR_KEY1 = 5'h05;
    localparam logic [4:0] ADDR_KEY2 = 5'h06;
    localparam logic [4:0] ADDR_KEY3 = 5'h07;
    localparam logic [4:0] ADDR_PT0  = 5'h08;
    localparam logic [4:0] ADDR_PT1  = 5'h09;
    localparam logic [4:0] ADDR_PT2  = 5'h0A;
    localparam logic [4:0] ADDR_PT3  = 5'h0B;
    localparam logic [4:0] ADDR_CT0  = 5'h0C;
    localparam logic [4:0] ADDR_CT1  = 5'h0D;
    localparam logic [4:0] ADDR_CT2  = 5'h0E;
    localparam logic [4:0] ADDR_CT3  = 5'h0F;
    localparam logic [4:0] ADDR_CTRL = 5'h10;
    localparam logic [4:0] ADDR_STA  = 5'h11;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_SA_BIT  = 1;
    localparam int CTRL_ENC_BIT = 2;
    localparam int CTRL_SOM_LSB = 3;
    localparam int CTRL_FB_BIT  = 5;

    // Word index limits: 12 data words then CTRL; 4 ciphertext words.
    localparam logic [3:0] WR_LAST_IDX = 4'd12;
    localparam logic [3:0] CT_LAST_IDX = 4'd3;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        POLL_REQ,
        POLL_CAP,
        CT_REQ,
        CT_CAP,
        DIS,
        DONE
    } state_t;

    function automatic logic [31:0] ctrl_word(input logic fb, input logic [1:0] som,
                                              input logic enc, input logic sa,
                                              input logic en);
        logic [31:0] w;
        w = '0;
        w[CTRL_EN_BIT]         = en;
        w[CTRL_SA_BIT]         = sa;
        w[CTRL_ENC_BIT]        = enc;
        w[CTRL_SOM_LSB +: 2]   = som;
        w[CTRL_FB_BIT]         = fb;
        return w;
    endfunction

endpackage

// File: rtl/ibr128_avm_master.sv
// Avalon-MM master that loads IV/key/PT into an IBR128 core, polls for
// completion and reads back the ciphertext. Optional poll timeout: IBR128_AVM_TIMEOUT_EN.
module ibr128_avm_master
    import ibr128_pkg::*;
#(
    parameter int POLL_MAX = 1024
) (
    input  logic         Clk,
    input  logic         RstN,
    input  logic         Start,
    input  logic [127:0] KeyIn,
    input  logic [127:0] IvIn,
    input  logic [127:0] PtIn,
    input  logic         ModeEncrypt,
    input  logic         ModeSA,
    input  logic [1:0]   ModeSOM,
    input  logic         ModeFB,
    output logic         Busy,
    output logic         Done,
    output logic         Err,
    output logic [127:0] CtOut,
    output logic         CS,
    output logic         Write,
    output logic         Read,
    output logic [4:0]   Addr,
    output logic [31:0]  WData,
    input  logic [31:0]  RData
);

    // Bus handshake: fixed-timing master with no wait states; a command is
    // valid for exactly the cycle CS is high, and read data is taken from
    // RData in the cycle right after the read command.

    state_t       state_q, state_d;
    logic [3:0]   idx_q, idx_d;
    logic [127:0] key_q, iv_q, pt_q, ct_q;
    logic         enc_q, sa_q, fb_q;
    logic [1:0]   som_q;
    logic         accept;
    logic         timeout;
    logic [6:0]   word_lsb;
    logic [31:0]  data_word;

    assign accept   = (state_q == IDLE) && Start;
    assign word_lsb = {idx_q[1:0], 5'd0};

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state_q <= IDLE;
            idx_q   <= '0;
            key_q   <= '0;
            iv_q    <= '0;
            pt_q    <= '0;
            ct_q    <= '0;
            enc_q   <= 1'b0;
            sa_q    <= 1'b0;
            fb_q    <= 1'b0;
            som_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (accept) begin
                key_q <= KeyIn;
                iv_q  <= IvIn;
                pt_q  <= PtIn;
                enc_q <= ModeEncrypt;
                sa_q  <= ModeSA;
                fb_q  <= ModeFB;
                som_q <= ModeSOM;
            end
            if (state_q == CT_CAP) begin
                ct_q[word_lsb +: 32] <= RData;
            end
        end
    end

`ifdef IBR128_AVM_TIMEOUT_EN
    localparam int CW = $clog2(POLL_MAX + 1);
    localparam logic [CW-1:0] POLL_LIMIT = CW'(POLL_MAX);

    logic [CW-1:0] poll_q;
    logic [CW-1:0] poll_inc;
    logic          err_q;

    assign poll_inc = poll_q + CW'(1);
    assign timeout  = (state_q == POLL_CAP) && !RData[0] && (poll_inc == POLL_LIMIT);
    assign Err      = err_q;

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            poll_q <= '0;
            err_q  <= 1'b0;
        end else if (accept) begin
            poll_q <= '0;
            err_q  <= 1'b0;
        end else if ((state_q == POLL_CAP) && !RData[0]) begin
            poll_q <= poll_inc;
            if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign timeout = 1'b0;
    assign Err     = 1'b0;

    // POLL_MAX has no effect while polling is unbounded.
    if (POLL_MAX < 1) begin : g_poll_max_ignored
    end
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d = WR;
                    idx_d   = '0;
                end
            end
            WR: begin
                if (idx_q == WR_LAST_IDX) begin
                    state_d = POLL_REQ;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            POLL_REQ: state_d = POLL_CAP;
            POLL_CAP: begin
                if (RData[0]) begin
                    state_d = CT_REQ;
                    idx_d   = '0;
                end else if (timeout) begin
                    state_d = DIS;
                end else begin
                    state_d = POLL_REQ;
                end
            end
            CT_REQ: state_d = CT_CAP;
            CT_CAP: begin
                if (idx_q == CT_LAST_IDX) begin
                    state_d = DIS;
                end else begin
                    state_d = CT_REQ;
                    idx_d   = idx_q + 4'd1;
                end
            end
            DIS:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        case (idx_q[3:2])
            2'd0:    data_word = iv_q[word_lsb +: 32];
            2'd1:    data_word = key_q[word_lsb +: 32];
            default: data_word = pt_q[word_lsb +: 32];
        endcase
    end

    always_comb begin
        CS    = 1'b0;
        Write = 1'b0;
        Read  = 1'b0;
        Addr  = '0;
        WData = '0;
        case (state_q)
            WR: begin
                CS    = 1'b1;
                Write = 1'b1;
                if (idx_q == WR_LAST_IDX) begin
                    Addr  = ADDR_CTRL;
                    WData = ctrl_word(fb_q, som_q, enc_q, sa_q, 1'b1);
                end else begin
                    Addr  = ADDR_IV0 + 5'(idx_q);
                    WData = data_word;
                end
            end
            POLL_REQ: begin
                CS   = 1'b1;
                Read = 1'b1;
                Addr = ADDR_STA;
            end
            CT_REQ: begin
                CS   = 1'b1;
                Read = 1'b1;
                Addr = ADDR_CT0 + 5'(idx_q);
            end
            DIS: begin
                CS    = 1'b1;
                Write = 1'b1;
                Addr  = ADDR_CTRL;
                WData = ctrl_word(fb_q, som_q, enc_q, sa_q, 1'b0);
            end
            default: begin
                CS = 1'b0;
            end
        endcase
    end

    assign Busy  = (state_q != IDLE);
    assign Done  = (state_q == DONE);
    assign CtOut = ct_q;

endmodule

// File: tb/tb_ibr128_avm_master.sv
// Directed bench for ibr128_avm_master with a CSR slave model and a bus
// scoreboard; the timeout case runs when IBR128_AVM_TIMEOUT_EN is defined.
module tb_ibr128_avm_master;

    logic         Clk = 1'b0;
    logic         RstN = 1'b0;
    logic         Start = 1'b0;
    logic [127:0] KeyIn = '0, IvIn = '0, PtIn = '0;
    logic         ModeEncrypt = 1'b0, ModeSA = 1'b0, ModeFB = 1'b0;
    logic [1:0]   ModeSOM = 2'b00;
    logic         Busy, Done, Err, CS, Write, Read;
    logic [127:0] CtOut;
    logic [4:0]   Addr;
    logic [31:0]  WData;
    logic [31:0]  RData;

    ibr128_avm_master #(.POLL_MAX(4)) dut (
        .Clk(Clk), .RstN(RstN), .Start(Start),
        .KeyIn(KeyIn), .IvIn(IvIn), .PtIn(PtIn),
        .ModeEncrypt(ModeEncrypt), .ModeSA(ModeSA), .ModeSOM(ModeSOM), .ModeFB(ModeFB),
        .Busy(Busy), .Done(Done), .Err(Err), .CtOut(CtOut),
        .CS(CS), .Write(Write), .Read(Read), .Addr(Addr), .WData(WData), .RData(RData)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag, input logic [127:0] obs);
        checks++;
        errors++;
        $error("FAIL %s: observed=%h expected=none", tag, obs);
    endtask

    function automatic logic [31:0] ctrl_w(input logic fb, input logic [1:0] som,
                                           input logic enc, input logic sa, input logic en);
        return {26'h0, fb, som, enc, sa, en};
    endfunction

    function automatic logic [127:0] model_ct(input logic [127:0] k, input logic [127:0] iv,
                                              input logic [127:0] pt, input logic [31:0] ctrl);
        logic [127:0] r;
        for (int i = 0; i < 4; i++) begin
            r[32*i +: 32] = pt[32*i +: 32] ^ k[32*i +: 32] ^
                            {iv[32*i +: 16], iv[32*i+16 +: 16]} ^ ctrl ^ (32'h01010101 << i);
        end
        return r;
    endfunction

    // Scoreboard queues
    logic [36:0]  exp_wr_q[$];
    logic [4:0]   exp_rd_q[$];
    logic [127:0] exp_ct_q[$];
    logic [127:0] last_ct = '0;

    // Slave model / monitor state
    logic [31:0] mem [0:31];
    logic [31:0] sl_ct [4];
    logic        sl_en = 1'b0;
    int          sl_cnt = 0;
    int          ready_after = 0;
    int          wr_count = 0, sta_reads = 0, ct_reads = 0, bus_count = 0, done_count = 0;
    logic        ct2_seen = 1'b0;
    logic [31:0] last_ctrl_en = '0, last_ctrl_dis = '0;
    int          accept_cyc = 0;

    always @(negedge Clk) begin
        if (!RstN) begin
            sl_en  = 1'b0;
            sl_cnt = 0;
            RData  = '0;
        end else begin
            if (sl_en) sl_cnt++;
            check("bus_protocol", 128'({Read & Write, CS != (Read | Write), !Write && (WData != 32'h0)}), 128'h0);
            if (Write) begin
                wr_count++;
                bus_count++;
                if (exp_wr_q.size() == 0) fail_now("write_unexpected", 128'({Addr, WData}));
                else check("write", 128'({Addr, WData}), 128'(exp_wr_q.pop_front()));
                mem[Addr] = WData;
                if (Addr == 5'h10) begin
                    sl_en  = WData[0];
                    sl_cnt = 0;
                    if (WData[0]) begin
                        last_ctrl_en = WData;
                        for (int i = 0; i < 4; i++)
                            sl_ct[i] = mem[8+i] ^ mem[4+i] ^ {mem[i][15:0], mem[i][31:16]} ^
                                       WData ^ (32'h01010101 << i);
                    end else begin
                        last_ctrl_dis = WData;
                    end
                end
            end
            if (Read) begin
                bus_count++;
                if (Addr == 5'h11) begin
                    sta_reads++;
                    RData = {31'h0, sl_en && (sl_cnt >= ready_after)};
                end else begin
                    ct_reads++;
                    if (Addr == 5'h0E) ct2_seen = 1'b1;
                    if (exp_rd_q.size() == 0) fail_now("read_unexpected", 128'(Addr));
                    else check("read_addr", 128'(Addr), 128'(exp_rd_q.pop_front()));
                    RData = sl_ct[Addr[1:0]];
                end
            end
            if (Done) done_count++;
        end
    end

    task automatic tick();
        @(negedge Clk);
        #1;
    endtask

    task automatic start_op(input logic [127:0] k, input logic [127:0] iv, input logic [127:0] pt,
                            input logic enc, input logic sa, input logic [1:0] som, input logic fb,
                            input logic expect_ct);
        tick();
        KeyIn = k; IvIn = iv; PtIn = pt;
        ModeEncrypt = enc; ModeSA = sa; ModeSOM = som; ModeFB = fb;
        wr_count = 0; sta_reads = 0; ct_reads = 0; done_count = 0; ct2_seen = 1'b0;
        for (int i = 0; i < 4; i++) exp_wr_q.push_back({5'(i), iv[32*i +: 32]});
        for (int i = 0; i < 4; i++) exp_wr_q.push_back({5'(4+i), k[32*i +: 32]});
        for (int i = 0; i < 4; i++) exp_wr_q.push_back({5'(8+i), pt[32*i +: 32]});
        exp_wr_q.push_back({5'h10, ctrl_w(fb, som, enc, sa, 1'b1)});
        exp_wr_q.push_back({5'h10, ctrl_w(fb, som, enc, sa, 1'b0)});
        if (expect_ct) begin
            for (int i = 0; i < 4; i++) exp_rd_q.push_back(5'(12+i));
            last_ct = model_ct(k, iv, pt, ctrl_w(fb, som, enc, sa, 1'b1));
        end
        exp_ct_q.push_back(last_ct);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        accept_cyc = cyc;
        check("busy_after_accept", 128'(Busy), 128'(1'b1));
        check("err_clear_on_accept", 128'(Err), 128'(1'b0));
    endtask

    task automatic finish_op(input string tag, input logic exp_err, input int exp_lat);
        int n;
        n = 0;
        while (!Done && n < 3000) begin
            tick();
            n++;
        end
        if (!Done) begin
            fail_now({tag, "_done_timeout"}, 128'(n));
        end else begin
            if (exp_lat > 0) check({tag, "_latency"}, 128'(cyc - accept_cyc), 128'(exp_lat));
            if (exp_ct_q.size() != 0) check({tag, "_ctout"}, CtOut, exp_ct_q.pop_front());
            check({tag, "_err"}, 128'(Err), 128'(exp_err));
            check({tag, "_done_count"}, 128'(done_count), 128'(1));
            check({tag, "_wr_q_drained"}, 128'(exp_wr_q.size()), 128'(0));
            check({tag, "_rd_q_drained"}, 128'(exp_rd_q.size()), 128'(0));
            tick();
            check({tag, "_done_pulse"}, 128'({Done, Busy}), 128'(2'b00));
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] k, iv, pt;
        int n;
        int bc;

        // Reset state
        repeat (3) tick();
        check("rst_outputs", 128'({Busy, Done, Err, CS, Write, Read, Addr, WData}), 128'h0);
        check("rst_ctout", CtOut, 128'h0);
        RstN = 1'b1;
        tick();

        // Canonical pattern, ready after 3 cycles, all modes 0
        ready_after = 3;
        k  = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
        iv = 128'h1F1E1D1C_1B1A1918_17161514_13121110;
        pt = 128'h2F2E2D2C_2B2A2928_27262524_23222120;
        start_op(k, iv, pt, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        finish_op("basic", 1'b0, 0);
        check("basic_ctrl_en", 128'(last_ctrl_en), 128'(32'h00000001));
        check("basic_ctrl_dis", 128'(last_ctrl_dis), 128'(32'h00000000));
        check("basic_wr_count", 128'(wr_count), 128'(14));

        // Ready on first poll: minimum latency, one STA read
        ready_after = 0;
        k  = {$urandom, $urandom, $urandom, $urandom};
        iv = {$urandom, $urandom, $urandom, $urandom};
        pt = {$urandom, $urandom, $urandom, $urandom};
        start_op(k, iv, pt, 1'b1, 1'b0, 2'(1), 1'b0, 1'b1);
        finish_op("minlat", 1'b0, 24);
        check("minlat_sta_reads", 128'(sta_reads), 128'(1));
        check("minlat_ct_reads", 128'(ct_reads), 128'(4));
        repeat (6) tick();
        check("ctout_hold_idle", CtOut, last_ct);

        // Start while busy is ignored; PT stays the latched value
        ready_after = 2;
        k  = {$urandom, $urandom, $urandom, $urandom};
        iv = {$urandom, $urandom, $urandom, $urandom};
        pt = {$urandom, $urandom, $urandom, $urandom};
        start_op(k, iv, pt, 1'b0, 1'b1, 2'b11, 1'b0, 1'b1);
        n = 0;
        while (wr_count < 5 && n < 100) begin
            tick();
            n++;
        end
        if (wr_count < 5) fail_now("ignore_wait_wr5", 128'(wr_count));
        PtIn  = ~pt;
        KeyIn = ~k;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        finish_op("ignore", 1'b0, 0);
        bc = bus_count;
        repeat (30) tick();
        check("ignore_no_second_op", 128'({Busy, 32'(bus_count - bc)}), 128'h0);

        // Mode fields in CTRL
        ready_after = 1;
        k  = {$urandom, $urandom, $urandom, $urandom};
        iv = {$urandom, $urandom, $urandom, $urandom};
        pt = {$urandom, $urandom, $urandom, $urandom};
        start_op(k, iv, pt, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1);
        finish_op("modes", 1'b0, 0);
        check("modes_ctrl_en", 128'(last_ctrl_en), 128'(32'h00000037));
        check("modes_ctrl_dis", 128'(last_ctrl_dis), 128'(32'h00000036));

`ifdef IBR128_AVM_TIMEOUT_EN
        // Slave never ready: timeout after POLL_MAX polls
        ready_after = 1000000;
        start_op({4{$urandom}}, {4{$urandom}}, {4{$urandom}}, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        finish_op("timeout", 1'b1, 0);
        check("timeout_sta_reads", 128'(sta_reads), 128'(4));
        check("timeout_ct_reads", 128'(ct_reads), 128'(0));
`endif

        // Reset during CT_REQ of word 2
        ready_after = 1;
        k  = {$urandom, $urandom, $urandom, $urandom};
        iv = {$urandom, $urandom, $urandom, $urandom};
        pt = {$urandom, $urandom, $urandom, $urandom};
        start_op(k, iv, pt, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1);
        n = 0;
        while (!ct2_seen && n < 200) begin
            tick();
            n++;
        end
        if (!ct2_seen) fail_now("midrst_wait_ct2", 128'(n));
        RstN = 1'b0;
        #1;
        check("midrst_outputs", 128'({Busy, Done, Err, CS, Write, Read, Addr, WData}), 128'h0);
        check("midrst_ctout", CtOut, 128'h0);
        exp_wr_q.delete();
        exp_rd_q.delete();
        exp_ct_q.delete();
        last_ct = '0;
        repeat (2) tick();
        RstN = 1'b1;
        bc = bus_count;
        repeat (10) tick();
        check("midrst_no_bus", 128'({Busy, 32'(bus_count - bc)}), 128'h0);

        // Fresh operation after reset
        k  = {$urandom, $urandom, $urandom, $urandom};
        iv = {$urandom, $urandom, $urandom, $urandom};
        pt = {$urandom, $urandom, $urandom, $urandom};
        start_op(k, iv, pt, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1);
        finish_op("after_rst", 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
